// File: rtl/echo_pkg.sv
// Shared types and widths for the ultrasound echo decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state enum, width constants and the slot-length helper.
package echo_pkg;

  localparam int PAT_W = 32;  // burst pattern width
  localparam int CNT_W = 32;  // cycle counters / time-of-flight
  localparam int HP_W  = 16;  // half_period / pulse_len / edge counter

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    BLANK  = 3'd1,
    SEEK   = 3'd2,
    DECODE = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Bit-slot length in clock cycles: 2*(half_period+1)*(pulse_len+1),
  // truncated to CNT_W bits (wraps silently on overflow).
  function automatic logic [CNT_W-1:0] slot_len(input logic [HP_W-1:0] half_period,
                                                input logic [HP_W-1:0] pulse_len);
    logic [CNT_W-1:0] hp_cycles;
    logic [CNT_W-1:0] periods;
    logic [CNT_W-1:0] prod;
    hp_cycles = {{(CNT_W-HP_W){1'b0}}, half_period} + CNT_W'(1);
    periods   = {{(CNT_W-HP_W){1'b0}}, pulse_len} + CNT_W'(1);
    prod      = hp_cycles * periods;
    return prod << 1;
  endfunction

endpackage

// File: rtl/echo_decoder_rx_edge_detect.sv
// Receive front end: 2-flop synchronizer, optional majority filter, rising-edge pulse.
// Latency: pin sampled at clock N -> rise high in cycle N+2 (N+4 with the filter).
// Backpressure: none; free-running sampler.
//
// Ports: clk, rst (sync, active-high), rx_in (async comparator output),
//        rise (one-cycle pulse on a 0->1 transition of the conditioned level).
// Build option ECHO_DECODER_GLITCH_FILTER_EN inserts a registered 3-sample
// majority vote after the synchronizer; isolated 1-cycle glitches never reach
// the edge detector.
module rx_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  output logic rise
);

  logic sync1;
  logic sync2;
  logic lvl;
  logic lvl_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= rx_in;
      sync2 <= sync1;
    end
  end

`ifdef ECHO_DECODER_GLITCH_FILTER_EN
  logic hist1;
  logic hist2;
  logic filt;

  // Vote over the current and two previous synchronized samples; a clean
  // edge needs two agreeing samples, which costs exactly two extra cycles
  // (one to accumulate the second sample, one for the output register).
  always_ff @(posedge clk) begin
    if (rst) begin
      hist1 <= 1'b0;
      hist2 <= 1'b0;
      filt  <= 1'b0;
    end else begin
      hist1 <= sync2;
      hist2 <= hist1;
      filt  <= (sync2 & hist1) | (sync2 & hist2) | (hist1 & hist2);
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync2;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      lvl_prev <= 1'b0;
    end else begin
      lvl_prev <= lvl;
    end
  end

  assign rise = lvl & ~lvl_prev;

endmodule

// File: rtl/echo_decoder.sv
// Echo decoder: aligns to the first carrier edge after tx_start, demodulates a
//   32-slot OOK burst, reports pattern/match/time-of-flight or no_echo.
// Latency: rx_valid in cycle E+32*L (E = accepted edge cycle, L = slot length).
// Backpressure: none; results are pulses plus held registers.
//
// Ports: clk, rst (sync, active-high), enable, tx_start, rx_in,
//        pattern/tx_period/half_period/pulse_len (captured on tx_start),
//        rx_pattern, rx_valid, match, tof, no_echo, busy.
// Build option ECHO_DECODER_GLITCH_FILTER_EN: see rx_edge_detect (adds 2 cycles to E).
module echo_decoder
  import echo_pkg::*;
#(
  parameter int BLANK_CYCLES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             tx_start,
  input  logic             rx_in,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] tx_period,
  input  logic [HP_W-1:0]  half_period,
  input  logic [HP_W-1:0]  pulse_len,
  output logic [PAT_W-1:0] rx_pattern,
  output logic             rx_valid,
  output logic             match,
  output logic [CNT_W-1:0] tof,
  output logic             no_echo,
  output logic             busy
);

  localparam logic [CNT_W:0] BLANK_LAST = (CNT_W+1)'(BLANK_CYCLES);

  state_t           state;
  state_t           state_nxt;

  // Measurement parameters captured on tx_start.
  logic [PAT_W-1:0] pattern_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] slot_len_q;
  logic [HP_W-1:0]  pulse_len_q;

  // One bit wider than tx_period so the "window expired" compare cannot wrap.
  logic [CNT_W:0]   elapsed;

  logic [CNT_W-1:0] slot_cnt;
  logic [HP_W-1:0]  edge_cnt;
  logic [4:0]       bit_idx;
  logic [PAT_W-1:0] shift_q;
  logic [CNT_W-1:0] tof_int;

  // Held results of the last completed measurement.
  logic [PAT_W-1:0] res_pattern;
  logic [CNT_W-1:0] res_tof;
  logic             res_match;

  logic             rise;
  logic             restart;
  logic             in_window;
  logic             slot_end;
  logic [HP_W-1:0]  edge_cnt_inc;
  logic [HP_W:0]    twice_cnt;
  logic [HP_W:0]    thresh;
  logic             bit_val;
  logic             go_decode;
  logic             decode_run;
  logic             commit;

  rx_edge_detect u_edge (
    .clk   (clk),
    .rst   (rst),
    .rx_in (rx_in),
    .rise  (rise)
  );

  assign restart   = enable & tx_start;
  assign in_window = (elapsed <= {1'b0, period_q});
  assign slot_end  = (slot_cnt == slot_len_q - CNT_W'(1));

  // Edge count for the current cycle, including an edge arriving right now.
  assign edge_cnt_inc = (rise && (edge_cnt != {HP_W{1'b1}})) ? edge_cnt + 1'b1 : edge_cnt;

  // Majority of carrier periods in the slot produced an edge:
  // 2*edge_cnt >= pulse_len+1, evaluated 17 bits wide.
  assign twice_cnt = {edge_cnt_inc, 1'b0};
  assign thresh    = {1'b0, pulse_len_q} + 1'b1;
  assign bit_val   = (twice_cnt >= thresh);

  // Next-state logic. Disable wins, then a restart, then normal progress.
  always_comb begin
    state_nxt = state;
    if (!enable) begin
      state_nxt = IDLE;
    end else if (tx_start) begin
      state_nxt = BLANK;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        BLANK:   if (elapsed >= BLANK_LAST) state_nxt = SEEK;
        SEEK: begin
          if (!in_window) begin
            state_nxt = IDLE;
          end else if (rise) begin
            state_nxt = DECODE;
          end
        end
        DECODE:  if (slot_end && (bit_idx == 5'd0)) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign go_decode  = (state == SEEK) && (state_nxt == DECODE);
  assign decode_run = (state == DECODE) && enable && !tx_start;

  // A DONE cycle that coincides with a restart (or with disable) belongs to an
  // abandoned measurement: it neither pulses rx_valid nor touches the results.
  assign commit = (state == DONE) && enable && !tx_start;

  // Results are presented in the DONE cycle itself, then held in res_*.
  assign rx_valid   = commit;
  assign rx_pattern = commit ? shift_q : res_pattern;
  assign match      = commit ? (shift_q == pattern_q) : res_match;
  assign tof        = commit ? tof_int : res_tof;
  assign no_echo    = (state == SEEK) && !in_window && enable && !tx_start;
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pattern_q   <= '0;
      period_q    <= '0;
      slot_len_q  <= '0;
      pulse_len_q <= '0;
      elapsed     <= '0;
      slot_cnt    <= '0;
      edge_cnt    <= '0;
      bit_idx     <= '0;
      shift_q     <= '0;
      tof_int     <= '0;
      res_pattern <= '0;
      res_tof     <= '0;
      res_match   <= 1'b0;
    end else begin
      state <= state_nxt;

      // elapsed == k in the k-th cycle after the tx_start cycle S,
      // so a capture in cycle E stores E-S directly.
      if (restart) begin
        pattern_q   <= pattern;
        period_q    <= tx_period;
        slot_len_q  <= slot_len(half_period, pulse_len);
        pulse_len_q <= pulse_len;
        elapsed     <= (CNT_W+1)'(1);
      end else if ((state == BLANK) || (state == SEEK)) begin
        elapsed <= elapsed + 1'b1;
      end

      if (go_decode) begin
        tof_int  <= elapsed[CNT_W-1:0];
        edge_cnt <= HP_W'(1);
        bit_idx  <= 5'd31;
        // The edge cycle E is position 0 of the first slot, so the next
        // cycle is position 1 and every slot spans exactly L cycles.
        slot_cnt <= CNT_W'(1);
      end else if (decode_run) begin
        if (slot_end) begin
          shift_q  <= {shift_q[PAT_W-2:0], bit_val};
          edge_cnt <= '0;
          slot_cnt <= '0;
          bit_idx  <= bit_idx - 1'b1;
        end else begin
          edge_cnt <= edge_cnt_inc;
          slot_cnt <= slot_cnt + 1'b1;
        end
      end

      if (commit) begin
        res_pattern <= shift_q;
        res_tof     <= tof_int;
        res_match   <= (shift_q == pattern_q);
      end
    end
  end

endmodule

// File: tb/tb_echo_decoder.sv
// Directed bench for echo_decoder: table of measurement vectors plus
// hand-written restart / disable / reset / glitch sequences.
module tb_echo_decoder;

`ifdef ECHO_DECODER_GLITCH_FILTER_EN
  localparam int FD = 2;
`else
  localparam int FD = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        tx_start;
  logic        rx_in;
  logic [31:0] pattern;
  logic [31:0] tx_period;
  logic [15:0] half_period;
  logic [15:0] pulse_len;
  logic [31:0] rx_pattern;
  logic        rx_valid;
  logic        match;
  logic [31:0] tof;
  logic        no_echo;
  logic        busy;

  echo_decoder #(.BLANK_CYCLES(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .tx_start    (tx_start),
    .rx_in       (rx_in),
    .pattern     (pattern),
    .tx_period   (tx_period),
    .half_period (half_period),
    .pulse_len   (pulse_len),
    .rx_pattern  (rx_pattern),
    .rx_valid    (rx_valid),
    .match       (match),
    .tof         (tof),
    .no_echo     (no_echo),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the clock edge that ends the current cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int S        = 0;

  // Event monitor, sampled on the falling edge.
  int          mon_valid = 0;
  int          mon_valid_cyc = -1;
  logic [31:0] mon_pat = '0;
  logic [31:0] mon_tof = '0;
  logic        mon_match = 1'b0;
  int          mon_noecho = 0;
  int          mon_noecho_cyc = -1;
  int          mon_fall_cyc = -1;
  logic        busy_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_valid) begin
      mon_valid++;
      mon_valid_cyc = cyc;
      mon_pat       = rx_pattern;
      mon_tof       = tof;
      mon_match     = match;
    end
    if (no_echo) begin
      mon_noecho++;
      mon_noecho_cyc = cyc;
    end
    if (busy_prev && !busy) mon_fall_cyc = cyc;
    busy_prev = busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pin waveform of an OOK burst: slot = 40 cycles, carrier period 10, 50% duty.
  function automatic logic pin_val(input int t, input logic [31:0] b);
    int slot;
    if (t < 0 || t >= 1280) return 1'b0;
    slot = t / 40;
    return b[31-slot] && ((t % 10) < 5);
  endfunction

  // Crosstalk pulses that all land inside the blanking interval.
  function automatic logic xt_val(input int t);
    return (t >= 2) && (t <= 58) && ((t % 4) < 2);
  endfunction

  // Issue tx_start with the common settings, then scramble the config inputs
  // so the decoder must rely on its captured copies.
  task automatic start_tx(input logic [31:0] cfg);
    pattern     = cfg;
    half_period = 16'd4;
    pulse_len   = 16'd3;
    tx_period   = 32'd4999;
    tx_start    = 1'b1;
    rx_in       = 1'b0;
    S           = cyc;
    step();
    tx_start    = 1'b0;
    pattern     = ~cfg;
    half_period = 16'd7;
    pulse_len   = 16'd9;
    tx_period   = 32'd100;
    check("busy_rise", 32'(busy), 32'd1);
  endtask

  task automatic run_window(input int n, input int off, input logic [31:0] burst, input bit xt);
    for (int i = 0; i < n; i++) begin
      rx_in = pin_val(cyc - S - off, burst) | (xt & xt_val(cyc - S));
      step();
    end
    rx_in = 1'b0;
  endtask

  typedef struct {
    logic [31:0] cfg;
    logic [31:0] burst;
    int          off;
    bit          xt;
    bit          valid;
    int          etof;
    logic [31:0] epat;
    bit          ematch;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          v0;
    int          n0;
    int          n;
    logic [31:0] hold_pat;
    logic [31:0] hold_tof;
    logic        hold_match;

    vecs[0] = '{32'hFF0055AA, 32'hFF0055AA, 1000,      1'b0, 1'b1, 1002 + FD, 32'hFF0055AA, 1'b1};
    vecs[1] = '{32'hFF0055AA, 32'h00000000, 0,         1'b0, 1'b0, 1002 + FD, 32'hFF0055AA, 1'b1};
    vecs[2] = '{32'h80000001, 32'h80000001, 2000,      1'b1, 1'b1, 2002 + FD, 32'h80000001, 1'b1};
    vecs[3] = '{32'hFF0055AA, 32'hFF0055AB, 1000,      1'b0, 1'b1, 1002 + FD, 32'hFF0055AB, 1'b0};
    vecs[4] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 4997 - FD, 1'b0, 1'b1, 4999,      32'hA5A5A5A5, 1'b1};
    vecs[5] = '{32'h12345678, 32'hC3C3C3C3, 4998 - FD, 1'b0, 1'b0, 4999,      32'hA5A5A5A5, 1'b1};

    rst = 1'b1; enable = 1'b1; tx_start = 1'b0; rx_in = 1'b0;
    pattern = '0; tx_period = 32'd4999; half_period = 16'd4; pulse_len = 16'd3;
    repeat (3) step();
    check("rst_rx_pattern", rx_pattern, 32'd0);
    check("rst_tof", tof, 32'd0);
    check("rst_match", 32'(match), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_no_echo", 32'(no_echo), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Table-driven measurements.
    for (int i = 0; i < 6; i++) begin
      v0 = mon_valid;
      n0 = mon_noecho;
      start_tx(vecs[i].cfg);
      n = vecs[i].valid ? vecs[i].etof + 1285 : 5004;
      run_window(n, vecs[i].off, vecs[i].burst, vecs[i].xt);
      repeat (5) step();
      check($sformatf("v%0d_valid_cnt", i), 32'(mon_valid - v0), 32'(vecs[i].valid));
      check($sformatf("v%0d_noecho_cnt", i), 32'(mon_noecho - n0), 32'(!vecs[i].valid));
      if (vecs[i].valid) begin
        check($sformatf("v%0d_valid_cyc", i), 32'(mon_valid_cyc), 32'(S + vecs[i].etof + 1280));
        check($sformatf("v%0d_valid_pat", i), mon_pat, vecs[i].epat);
        check($sformatf("v%0d_valid_tof", i), mon_tof, 32'(vecs[i].etof));
        check($sformatf("v%0d_valid_match", i), 32'(mon_match), 32'(vecs[i].ematch));
        check($sformatf("v%0d_busy_fall", i), 32'(mon_fall_cyc), 32'(S + vecs[i].etof + 1281));
      end else begin
        check($sformatf("v%0d_noecho_cyc", i), 32'(mon_noecho_cyc), 32'(S + 5000));
        check($sformatf("v%0d_busy_fall", i), 32'(mon_fall_cyc), 32'(S + 5001));
      end
      check($sformatf("v%0d_hold_pat", i), rx_pattern, vecs[i].epat);
      check($sformatf("v%0d_hold_tof", i), tof, 32'(vecs[i].etof));
      check($sformatf("v%0d_hold_match", i), 32'(match), 32'(vecs[i].ematch));
    end

    // Restart mid-DECODE: only the second burst may report.
    v0 = mon_valid;
    start_tx(32'hFFFFFFFF);
    run_window(601 + FD, 200, 32'hFFFFFFFF, 1'b0);
    start_tx(32'hF0F0F0F0);
    run_window(1002 + FD + 1285, 1000, 32'hF0F0F0F0, 1'b0);
    repeat (5) step();
    check("restart_valid_cnt", 32'(mon_valid - v0), 32'd1);
    check("restart_valid_cyc", 32'(mon_valid_cyc), 32'(S + 1002 + FD + 1280));
    check("restart_tof", mon_tof, 32'(1002 + FD));
    check("restart_pat", mon_pat, 32'hF0F0F0F0);
    check("restart_match", 32'(mon_match), 32'd1);
    hold_pat = rx_pattern; hold_tof = tof; hold_match = match;

    // Enable low mid-DECODE: back to IDLE, measurement dropped, results held.
    v0 = mon_valid;
    n0 = mon_noecho;
    start_tx(32'hFF0055AA);
    run_window(302 + FD, 100, 32'hFF0055AA, 1'b0);
    check("en_busy_before", 32'(busy), 32'd1);
    enable = 1'b0;
    step();
    check("en_busy_off", 32'(busy), 32'd0);
    enable = 1'b1;
    run_window(1300, 100, 32'hFF0055AA, 1'b0);
    check("en_valid_cnt", 32'(mon_valid - v0), 32'd0);
    check("en_noecho_cnt", 32'(mon_noecho - n0), 32'd0);
    check("en_busy_end", 32'(busy), 32'd0);
    check("en_hold_pat", rx_pattern, hold_pat);
    check("en_hold_tof", tof, hold_tof);
    check("en_hold_match", 32'(match), 32'(hold_match));

    // Synchronous reset mid-DECODE clears everything.
    start_tx(32'h80000001);
    run_window(302 + FD, 100, 32'h80000001, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_rx_pattern", rx_pattern, 32'd0);
    check("mrst_tof", tof, 32'd0);
    check("mrst_match", 32'(match), 32'd0);
    check("mrst_rx_valid", 32'(rx_valid), 32'd0);
    check("mrst_no_echo", 32'(no_echo), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    repeat (5) step();

`ifdef ECHO_DECODER_GLITCH_FILTER_EN
    // Isolated 1-cycle glitches must never be accepted as an echo.
    v0 = mon_valid;
    n0 = mon_noecho;
    start_tx(32'hFF0055AA);
    for (int i = 0; i < 5004; i++) begin
      rx_in = ((cyc - S) > 100) && (((cyc - S) % 50) == 0);
      step();
    end
    rx_in = 1'b0;
    repeat (5) step();
    check("glitch_valid_cnt", 32'(mon_valid - v0), 32'd0);
    check("glitch_noecho_cnt", 32'(mon_noecho - n0), 32'd1);
    check("glitch_noecho_cyc", 32'(mon_noecho_cyc), 32'(S + 5000));
    check("glitch_tof", tof, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/echo_decoder.md
# echo_decoder

Receive-side counterpart of `pulse_generator`. It takes the digitized echo from the ultrasound receiver comparator and aligns to the first carrier edge after a transmit start. It then demodulates the on/off-keyed 32-bit burst pattern slot by slot and reports the decoded pattern, a match flag and time-of-flight in clock cycles. It sits between the receiver front-end comparator and the sonar ranging/control logic, and shares its timing inputs with `pulse_generator`.

## Interface
Parameters:
- `BLANK_CYCLES`, 64: cycles after `tx_start` during which echo edges are ignored (direct crosstalk).

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `enable`  in  1  decoder enable; low forces IDLE
- `tx_start`  in  1  one-cycle pulse from transmitter at burst start
- `rx_in`  in  1  asynchronous comparator output
- `pattern`  in  32  expected pattern, MSB first; bit 31 must be 1
- `tx_period`  in  32  measurement window, cycles
- `half_period`  in  16  carrier half period minus 1, cycles
- `pulse_len`  in  16  carrier periods per bit slot minus 1
- `rx_pattern`  out  32  last decoded pattern
- `rx_valid`  out  1  one-cycle pulse: new result
- `match`  out  1  `rx_pattern == pattern`, updated with `rx_valid`
- `tof`  out  32  cycles from `tx_start` to first accepted edge
- `no_echo`  out  1  one-cycle pulse: window expired without an edge
- `busy`  out  1  high in any state except IDLE

## Operation
- `rx_in` passes through a 2-flop synchronizer, then rising-edge detection. The edge event cycle E is the first cycle in which the synchronized level is 1 after a 0.
- Slot length L = 2·(half_period+1)·(pulse_len+1). It is computed and latched on `tx_start` in 32-bit unsigned arithmetic, with no overflow checking.
- FSM states:
  - IDLE: on `tx_start` && `enable`, latch S, go to BLANK.
  - BLANK: lasts `BLANK_CYCLES` cycles; edges ignored; then go to SEEK.
  - SEEK: the first edge at cycle E ≤ S+`tx_period` sets `tof`=E−S, slot_cnt=0, edge_cnt=1, bit_idx=31, and moves to DECODE. If none arrives, `no_echo` pulses at S+`tx_period`+1 and the FSM returns to IDLE.
  - DECODE: each edge increments edge_cnt, saturating at 0xFFFF. At slot_cnt==L−1 the bit is 1 iff 2·edge_cnt ≥ pulse_len+1, with the count including an edge in that same cycle and the compare done in 17-bit arithmetic. The bit shifts into an internal register MSB first; edge_cnt and slot_cnt clear. After bit 0 the FSM goes to DONE.
  - DONE: for one cycle, updates `rx_pattern`, `match`, `tof` and pulses `rx_valid`, then returns to IDLE.
- `tx_start` in any non-IDLE state, with `enable` high, aborts and restarts at BLANK. No `rx_valid` is produced for the aborted measurement. This takes priority over a simultaneous slot end or DONE.
- `enable` low in any state returns to IDLE next cycle. Result outputs hold their values.
- Result outputs hold until the next DONE. A timeout leaves them unchanged.

## Timing
- Reset values: `rx_pattern`=0, `tof`=0, `match`=0, `rx_valid`=0, `no_echo`=0, `busy`=0; FSM in IDLE; synchronizer flops 0.
- A pin rising edge sampled at clock N gives E=N+2 (base build).
- `rx_valid` is high in cycle E+32·L.
- `busy` rises the cycle after `tx_start`.
- `half_period`, `pulse_len`, `tx_period` and `pattern` are sampled on `tx_start` and held internally.

## Configuration
- `ECHO_DECODER_GLITCH_FILTER_EN` defined: a 3-sample majority filter, registered, is inserted after the synchronizer. E shifts by exactly +2 cycles for clean edges, and isolated 1-cycle glitches are rejected.
- Not defined: the edge is detected directly on the synchronizer output; no extra latency.

## Structure
- Package `echo_pkg`: FSM state enum (IDLE, BLANK, SEEK, DECODE, DONE) and width constants `PAT_W`=32, `CNT_W`=32, `HP_W`=16.
- Sub-module `rx_edge_detect`: synchronizer, optional majority filter and rising-edge pulse output.

## Test plan
Common settings: `half_period`=4, `pulse_len`=3, so L=40 and the threshold is edge_cnt ≥ 2; `tx_period`=4999.
- Clean echo: `tx_start` at S, burst of 0xFF0055AA starting at pin cycle S+1000 → `tof`=1002 (1004 with filter), `rx_pattern`=0xFF0055AA, `match`=1, `rx_valid` at E+1280.
- No echo: `tx_start`, `rx_in` held 0 → `no_echo` at S+5000, `busy` low at S+5001, results unchanged.
- Blanking: edges only during S+1..S+64, then the real burst at S+2000 → crosstalk ignored, `tof`=2002.
- Mismatch: `pattern`=0xFF0055AA, received 0xFF0055AB → `match`=0, `rx_pattern`=0xFF0055AB.
- Restart: second `tx_start` mid-DECODE → no `rx_valid` for the first burst, new `tof` measured from the second S.
- Reset/enable: `rst` or `enable`=0 mid-DECODE → IDLE next cycle; after `rst` all outputs are 0. With the filter built in, 1-cycle glitches on `rx_in` → no `tof` capture.
